// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline registers (if_id, id_ex, ex_mem, mem_wb).
package pipe_pkg;

  localparam int XLEN     = 32;
  localparam int RD_LSB   = 7;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;
  localparam int OPCODE_W = 7;

  // addi x0,x0,0: the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pipe_if_id_sat_counter.sv
// Saturating up-counter with synchronous clear; reset overrides clear, clear overrides increment.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                   cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_if_id.sv
// IF/ID pipeline register with valid bit, stall/flush, NOP substitution and stall/flush counters.
import pipe_pkg::*;

module pipe_if_id #(
  parameter int          ADDRESS_WIDTH  = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter int          CNT_WIDTH      = 16,
  parameter logic [31:0] NOP_INSTR      = pipe_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     rd,
  input  logic [ADDRESS_WIDTH-1:0]  pcf,
  input  logic [ADDRESS_WIDTH-1:0]  pcplus4f,
  input  logic                      validf,
  input  logic                      stalld,
  input  logic                      flushd,
  input  logic                      clr_cnt,
  output logic [DATA_WIDTH-1:0]     instrd,
  output logic [ADDRESS_WIDTH-1:0]  pcd,
  output logic [ADDRESS_WIDTH-1:0]  pcplus4d,
  output logic                      validd,
  output logic [REG_ADDR_WIDTH-1:0] rdd,
  output logic [REG_ADDR_WIDTH-1:0] rs1d,
  output logic [REG_ADDR_WIDTH-1:0] rs2d,
  output logic [OPCODE_W-1:0]       opcoded,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  // The slot struct is sized by the package XLEN; the width parameters track it.
  if_id_t r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (flushd) begin
      r_d.instr = NOP_INSTR;
      r_d.valid = 1'b0;
    end else if (!stalld) begin
      r_d.pc      = pcf;
      r_d.pcplus4 = pcplus4f;
      r_d.valid   = validf;
      r_d.instr   = validf ? rd : NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.instr   <= NOP_INSTR;
      r_q.pc      <= '0;
      r_q.pcplus4 <= '0;
      r_q.valid   <= 1'b0;
    end else begin
      r_q <= r_d;
    end
  end

  assign instrd   = r_q.instr;
  assign pcd      = r_q.pc;
  assign pcplus4d = r_q.pcplus4;
  assign validd   = r_q.valid;

  // Fields come from the registered word, so bubbles decode as x0 everywhere.
  assign rdd     = r_q.instr[RD_LSB  +: REG_ADDR_WIDTH];
  assign rs1d    = r_q.instr[RS1_LSB +: REG_ADDR_WIDTH];
  assign rs2d    = r_q.instr[RS2_LSB +: REG_ADDR_WIDTH];
  assign opcoded = r_q.instr[0 +: OPCODE_W];

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stalld && !flushd && r_q.valid),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flushd),
    .clr   (clr_cnt),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_if_id.sv
// Scoreboard bench for pipe_if_id: default instance plus a 4-bit-counter instance on shared stimulus.
module tb_pipe_if_id;

  logic        clk = 1'b0;
  logic        rst, validf, stalld, flushd, clr_cnt;
  logic [31:0] rd, pcf, pcplus4f;

  logic [31:0] instrd, pcd, pcplus4d, instrd4, pcd4, pcplus4d4;
  logic        validd, validd4;
  logic [4:0]  rdd, rs1d, rs2d, rdd4, rs1d4, rs2d4;
  logic [6:0]  opcoded, opcoded4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  pipe_if_id dut (
    .clk(clk), .rst(rst), .rd(rd), .pcf(pcf), .pcplus4f(pcplus4f), .validf(validf),
    .stalld(stalld), .flushd(flushd), .clr_cnt(clr_cnt),
    .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d), .validd(validd),
    .rdd(rdd), .rs1d(rs1d), .rs2d(rs2d), .opcoded(opcoded),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_if_id #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .rd(rd), .pcf(pcf), .pcplus4f(pcplus4f), .validf(validf),
    .stalld(stalld), .flushd(flushd), .clr_cnt(clr_cnt),
    .instrd(instrd4), .pcd(pcd4), .pcplus4d(pcplus4d4), .validd(validd4),
    .rdd(rdd4), .rs1d(rs1d4), .rs2d(rs2d4), .opcoded(opcoded4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    logic [31:0] instr, pc, pc4;
    logic        valid;
    int          sc, fc, sc4, fc4;
  } exp_t;

  exp_t  q[$];
  int    total = 0, bad = 0;
  bit    done = 0;

  // Reference model: decode slot as plain variables, counters as bounded integers.
  logic [31:0] m_instr = 32'h13, m_pc = 0, m_pc4 = 0;
  logic        m_valid = 0;
  int          m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

  function automatic int bump(int c, bit inc, bit clr, int maxv);
    if (clr) return 0;
    if (inc && c < maxv) return c + 1;
    return c;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   s_inc;
    if (rst) begin
      m_instr = 32'h13; m_pc = 0; m_pc4 = 0; m_valid = 0;
      m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    end else begin
      s_inc = stalld && !flushd && m_valid;
      m_sc  = bump(m_sc,  s_inc,  clr_cnt, 65535);
      m_sc4 = bump(m_sc4, s_inc,  clr_cnt, 15);
      m_fc  = bump(m_fc,  flushd, clr_cnt, 65535);
      m_fc4 = bump(m_fc4, flushd, clr_cnt, 15);
      if (flushd) begin
        m_instr = 32'h13; m_valid = 0;
      end else if (!stalld) begin
        m_pc = pcf; m_pc4 = pcplus4f; m_valid = validf;
        m_instr = validf ? rd : 32'h13;
      end
    end
    e.instr = m_instr; e.pc = m_pc; e.pc4 = m_pc4; e.valid = m_valid;
    e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
    q.push_back(e);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("instrd",     instrd,            e.instr);
      chk("pcd",        pcd,               e.pc);
      chk("pcplus4d",   pcplus4d,          e.pc4);
      chk("validd",     {31'b0, validd},   {31'b0, e.valid});
      chk("rdd",        {27'b0, rdd},      {27'b0, e.instr[11:7]});
      chk("rs1d",       {27'b0, rs1d},     {27'b0, e.instr[19:15]});
      chk("rs2d",       {27'b0, rs2d},     {27'b0, e.instr[24:20]});
      chk("opcoded",    {25'b0, opcoded},  {25'b0, e.instr[6:0]});
      chk("stall_cnt",  {16'b0, stall_cnt},  e.sc);
      chk("flush_cnt",  {16'b0, flush_cnt},  e.fc);
      chk("stall_cnt4", {28'b0, stall_cnt4}, e.sc4);
      chk("flush_cnt4", {28'b0, flush_cnt4}, e.fc4);
      chk("instrd4",    instrd4,           e.instr);
      chk("validd4",    {31'b0, validd4},  {31'b0, e.valid});
      chk("pcd4",       pcd4 ^ pcplus4d4,  e.pc ^ e.pc4);
      chk("fields4",    {12'b0, rdd4, rs1d4, rs2d4, opcoded4},
                        {12'b0, e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[6:0]});
    end
  end

  task automatic cyc(bit r, logic [31:0] d, logic [31:0] pc, bit vf, bit st, bit fl, bit cl);
    rst = r; rd = d; pcf = pc; pcplus4f = pc + 4; validf = vf;
    stalld = st; flushd = fl; clr_cnt = cl;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; rd = 32'h00A00093; pcf = 0; pcplus4f = 4; validf = 1;
    stalld = 0; flushd = 0; clr_cnt = 0;
    @(posedge clk); #1;
    cyc(1, 32'h00A00093, 32'h0, 1, 0, 0, 0);
    // load, stall x3 with changing inputs, release
    cyc(0, 32'h00A00093, 32'h100, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'h12345678 + i, 32'h200 + 4*i, 1, 1, 0, 0);
    cyc(0, 32'h002081B3, 32'h300, 1, 0, 0, 0);
    // flush overrides stall
    cyc(0, 32'h00B00113, 32'h304, 1, 1, 1, 0);
    // invalid fetch carries a bubble
    cyc(0, 32'hFFFFFFFF, 32'h308, 0, 0, 0, 0);
    // saturate the 4-bit stall counter, then clear alongside a stall
    cyc(0, 32'h40B50533, 32'h400, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, $urandom, $urandom, 1, 1, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 1, 0, 1);
    // reset mid-stall
    cyc(0, 32'h00C00193, 32'h500, 1, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 1, 0, 0);
    cyc(1, 32'h0, 32'h0, 1, 1, 0, 0);
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 99) == 0), $urandom, $urandom,
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3));
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() > 1) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want<=1", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_if_id.md
# pipe_if_id

Parametrised fetch-to-decode pipeline register for the pipelined RV32I core, and the successor of the plain IF/ID register. It sits between instruction-memory read / PC logic and the decode stage. It adds:
- a valid bit;
- hazard-unit stall (hold) and branch flush (bubble injection);
- canonical-NOP substitution;
- registered source/destination register-field outputs;
- two saturating performance counters for stall and flush cycles.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, PC width
- DATA_WIDTH, 32, instruction width (must be ≥ 32)
- REG_ADDR_WIDTH, 5, register-index width
- CNT_WIDTH, 16, performance-counter width
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rd  in  DATA_WIDTH  instruction word from instruction memory
- pcf  in  ADDRESS_WIDTH  fetch PC
- pcplus4f  in  ADDRESS_WIDTH  fetch PC+4
- validf  in  1  fetch slot holds a real instruction
- stalld  in  1  hazard unit: hold current contents
- flushd  in  1  branch/jump resolved taken: kill decode slot
- clr_cnt  in  1  synchronous clear of both counters
- instrd  out  DATA_WIDTH  registered instruction
- pcd  out  ADDRESS_WIDTH  registered PC
- pcplus4d  out  ADDRESS_WIDTH  registered PC+4
- validd  out  1  decode slot valid
- rdd, rs1d, rs2d  out  REG_ADDR_WIDTH  instrd[11:7], [19:15], [24:20]
- opcoded  out  7  instrd[6:0]
- stall_cnt, flush_cnt  out  CNT_WIDTH  performance counters

## Operation
Per-cycle update, in priority order:
1. **rst:** instrd=NOP_INSTR, pcd=0, pcplus4d=0, validd=0, stall_cnt=0, flush_cnt=0.
2. **flushd=1:** instrd=NOP_INSTR, validd=0, pcd/pcplus4d hold. flushd overrides stalld.
3. **stalld=1:** all data outputs and validd hold.
4. **Otherwise (load):**
   - pcd←pcf, pcplus4d←pcplus4f, validd←validf.
   - instrd←rd if validf=1, else NOP_INSTR.

Rules:
- Invalid slots always carry NOP_INSTR, so rdd=rs1d=rs2d=0 whenever validd=0. Downstream forwarding and hazard logic need no valid gating.
- Field outputs are combinational slices of instrd. They must never be driven from rd.

Counters:
- stall_cnt increments on cycles with stalld=1, flushd=0, validd=1.
- flush_cnt increments on cycles with flushd=1.
- Both saturate at all-ones; they never wrap.
- clr_cnt=1 zeroes both counters and takes priority over increment. rst overrides clr_cnt.
- Counters do not affect the datapath.

## Timing
- Latency 1 cycle from fetch inputs to decode outputs; no combinational input→output path.
- A stall holds for exactly as many cycles as stalld is high. The first load occurs on the first edge with stalld=0.
- flushd asserted for one edge kills the slot for the next cycle. If validf=1 on the following edge, normal loading resumes.
- Reset mid-stall or mid-flush: reset values on the next edge; stall/flush state is not remembered.
- Simultaneous clr_cnt and increment condition: counter becomes 0.

## Structure
Shared package pipe_pkg holds:
- NOP_INSTR constant;
- field-position localparams (RD_LSB=7, RS1_LSB=15, RS2_LSB=20, OPCODE_W=7);
- typedef struct if_id_t {instr, pc, pcplus4, valid}.

Later pipe stages (id_ex, ex_mem, mem_wb) reuse this package. One sub-module, sat_counter (CNT_WIDTH, inc, clr, count), is instantiated twice for the counters. The datapath register is a single if_id_t flop with priority mux.

## Test plan
- **Reset:** assert rst with rd=32'h00A00093 → instrd=32'h00000013, validd=0, rdd=0, pcd=0, counters 0.
- **Load:** rd=32'h00A00093, pcf=0x100, pcplus4f=0x104, validf=1 → next cycle instrd=0x00A00093, rdd=1, rs1d=0, opcoded=7'h13, pcd=0x100, validd=1.
- **Stall:** stalld=1 for 3 cycles while rd/pcf change → outputs hold 0x00A00093/0x100; stall_cnt=3. Release → new values load on the next edge.
- **Flush vs. stall:** flushd=1 and stalld=1 simultaneously → instrd=NOP, validd=0, flush_cnt=1, stall_cnt unchanged.
- **validf=0 load:** rd=0xFFFFFFFF → instrd=NOP, rdd=rs1d=rs2d=0, validd=0.
- **Counter saturation:** CNT_WIDTH=4, 20 stall cycles → stall_cnt=15. clr_cnt=1 alongside a stall cycle → 0.
